// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - shares one external adder between NUM_REQ requesters
// Define ADDER_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module adder_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic                     add_rstn,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_carry
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(ADD_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
    logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               add_rstn_q;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [WIDTH-1:0]   sel_a, sel_b;

`ifndef ADDER_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W:0]     rr_sum;
    logic [IDX_W-1:0]   rr_idx;
`endif

    always_comb begin
        found = 1'b0;
        win   = '0;
`ifdef ADDER_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
`else
        rr_sum = '0;
        rr_idx = '0;
        // Search starts at the pointer and wraps modulo NUM_REQ.
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
            end
            rr_idx = rr_sum[IDX_W-1:0];
            if (!found && req_valid[rr_idx]) begin
                found = 1'b1;
                win   = rr_idx;
            end
        end
`endif
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IDX_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
`ifndef ADDER_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    add_a_d = sel_a;
                    add_b_d = sel_b;
                    grant_d = win;
                    cnt_d   = CNT_W'(ADD_LAT);
                    state_d = S_WAIT;
`ifndef ADDER_ARB_FIXED_PRIO_EN
                    ptr_d   = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    rsp_sum_d   = add_sum;
                    rsp_carry_d = add_carry;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready[grant_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            add_rstn_q  <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            add_rstn_q  <= 1'b1;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !rst && (state_q == S_IDLE) && found && (win == IDX_W'(i));
            rsp_valid[i] = (state_q == S_RESP) && (grant_q == IDX_W'(i));
        end
    end

    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_rstn  = add_rstn_q;

endmodule
